// File: rtl/accel_pkg.sv
// accel_pkg: shared state encoding, counter sizing helpers and accelerometer register map
package accel_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_TICK, BUSY, FAULT} state_t;
    localparam logic [7:0] ACC_REG_DATAX0 = 8'h32;
    localparam logic [7:0] ACC_REG_DATAX1 = 8'h33;
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction
    function automatic int us_to_cycles(input int us, input int clk_ns);
        return us * 1000 / clk_ns;
    endfunction
endpackage

// File: rtl/poll_tick_gen.sv
// poll_tick_gen: reloadable down-counter; tick fires while enabled at zero and reloads RELOAD
module poll_tick_gen import accel_pkg::*; #(
    parameter int RELOAD = 99
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tick
);
    localparam int W = cnt_width(RELOAD);
    logic [W-1:0] cnt;
    assign tick = en && cnt == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= '0;
        else if (tick) cnt <= W'(RELOAD);
        else if (en) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/accel_poll_ctrl.sv
// accel_poll_ctrl: periodic I2C X-axis poll with hysteresis brake classification and fail-safe fault
module accel_poll_ctrl import accel_pkg::*; #(
    parameter int         CLK_PERIOD   = 480,
    parameter int         POLL_PERIOD  = 10000,
    parameter logic [7:0] REG_ADDR     = ACC_REG_DATAX0,
    parameter int         BRAKE_THRESH = 300,
    parameter int         HYST         = 50,
    parameter int         ACK_TIMEOUT  = 4096,
    parameter int         MAX_ERR      = 3,
    parameter logic       FAULT_BRAKE  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        i2c_req,
    output logic [7:0]  i2c_reg,
    input  logic        i2c_ack,
    input  logic        i2c_err,
    input  logic [15:0] i2c_rdata,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        brake_raw,
    output logic        overrun,
    output logic        fault,
    output logic [7:0]  err_cnt
);
    localparam int POLL_CLK_CNT = us_to_cycles(POLL_PERIOD, CLK_PERIOD);
    localparam int TW = cnt_width(ACK_TIMEOUT);
    localparam int CW = cnt_width(MAX_ERR);
    localparam logic signed [16:0] SET_LVL = 17'(-BRAKE_THRESH);
    localparam logic signed [16:0] CLR_LVL = 17'(-(BRAKE_THRESH - HYST));

    state_t state, state_nx;
    logic tick, done_ok, done_err, err_trip, timeout, brk, brk_nx;
    logic [TW-1:0] to_cnt;
    logic [CW-1:0] consec;
    logic signed [16:0] rd_ext;

    poll_tick_gen #(.RELOAD(POLL_CLK_CNT - 1)) u_tick (
        .clk(clk),
        .rst_n(rst_n),
        .load(state == IDLE),
        .en(state == WAIT_TICK || state == BUSY),
        .tick(tick)
    );

    assign rd_ext   = {i2c_rdata[15], i2c_rdata};
    // Hysteresis: once braking, only a sample above the release level clears it
    assign brk_nx   = brk ? (rd_ext <= CLR_LVL) : (rd_ext <= SET_LVL);
    assign timeout  = to_cnt == TW'(ACK_TIMEOUT - 1);
    assign done_ok  = state == BUSY && i2c_ack;
    assign done_err = state == BUSY && !i2c_ack && (i2c_err || timeout);
    assign err_trip = done_err && int'(consec) + 1 >= MAX_ERR;

    assign i2c_req   = state == BUSY;
    assign i2c_reg   = REG_ADDR;
    assign fault     = state == FAULT;
    assign brake_raw = (state == FAULT) ? FAULT_BRAKE : (state != IDLE) && brk;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = enable ? WAIT_TICK : IDLE;
            WAIT_TICK: state_nx = !enable ? IDLE : tick ? BUSY : WAIT_TICK;
            BUSY:      state_nx = err_trip ? FAULT : (done_ok || done_err) ? (enable ? WAIT_TICK : IDLE) : BUSY;
            FAULT:     state_nx = enable ? FAULT : IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            to_cnt       <= '0;
            consec       <= '0;
            brk          <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            err_cnt      <= '0;
        end else begin
            state        <= state_nx;
            to_cnt       <= (state == BUSY) ? to_cnt + 1'b1 : '0;
            sample_valid <= done_ok;
            overrun      <= enable && (overrun || (state == BUSY && tick));
            if (done_ok) begin
                sample <= i2c_rdata;
                brk    <= brk_nx;
            end else if (state == IDLE) begin
                brk <= 1'b0;
            end
            if (done_ok || (state == FAULT && !enable)) consec <= '0;
            else if (done_err) consec <= consec + 1'b1;
            if (done_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule
